cpu_debug_ocimem_ctrl: RTL and testbench
========================================

Name: cpu_debug_ocimem_ctrl

Overview:
On-chip debug memory controller. It sits directly downstream of the CPU debug-slave wrapper, which produces `jdo` and the `take_*_ocimem_*` strobes; this block consumes them.
- Owns the monitor RAM and arbitrates between two masters: the JTAG host path (via `jdo`) and the CPU's Avalon-MM debug-memory slave port.
- Returns read data to the debug slave on `MonDReg`, closing the JTAG read loop.

Parameters:
- ADDR_W, 8, word-address width of the monitor RAM (2^ADDR_W 32-bit words).
- DATA_W, 32, data width; fixed at 32, other values unsupported.

Ports:
- clk  in  1  system clock; single clock domain. The strobes arrive already synchronised to clk.
- reset  in  1  asynchronous, active-high reset.
- jdo  in  38  JTAG data-out bus from the debug slave.
- take_action_ocimem_a  in  1  one-cycle pulse: load address and read flag from `jdo`.
- take_no_action_ocimem_a  in  1  one-cycle pulse: sequential read (increment address, then read).
- take_action_ocimem_b  in  1  one-cycle pulse: load write data from `jdo`, then write.
- address  in  ADDR_W  Avalon word address.
- read  in  1  Avalon read request.
- write  in  1  Avalon write request.
- writedata  in  32  Avalon write data.
- byteenable  in  4  Avalon byte lanes.
- debugaccess  in  1  Avalon writes take effect only when this is 1.
- readdata  out  32  Avalon read data.
- waitrequest  out  1  Avalon stall.
- MonDReg  out  32  JTAG-side data register, read by the debug slave.
- MonAReg  out  ADDR_W  JTAG-side address register (observability).

Behaviour:
- Reset (async, active-high): the following are cleared to 0 and the FSM goes to IDLE.
  - MonDReg, MonAReg, readdata.
  - Pending flags jrd_pend and jwr_pend.
  - waitrequest is forced to 1 while reset is asserted.
  - RAM contents are not reset.
- jdo field map:
  - jdo[17 +: ADDR_W] = address.
  - jdo[35] = read request.
  - jdo[34:3] = write data.
- Strobe handling:
  - take_action_ocimem_a: MonAReg <= jdo address field; jrd_pend <= jdo[35].
  - take_no_action_ocimem_a: MonAReg <= MonAReg+1, wrapping modulo 2^ADDR_W; jrd_pend <= 1.
  - take_action_ocimem_b: MonDReg <= jdo[34:3]; jwr_pend <= 1.
  - If strobes coincide, a/no_action_a are applied together with b. jwr_pend is served before jrd_pend.
  - A strobe arriving while its pend flag is already set overwrites the register fields. The pend flag stays set; only one access is performed.
- FSM states: IDLE, JWR, JRD, JRD_CAP, AV_RD, AV_RD_CAP.
  - IDLE priority: jwr_pend > jrd_pend > Avalon write > Avalon read.
  - JWR: writes MonDReg to RAM[MonAReg] with all byte lanes; clears jwr_pend; returns to IDLE.
  - JRD: presents MonAReg to the RAM; next state JRD_CAP.
  - JRD_CAP: MonDReg <= RAM data; clears jrd_pend; returns to IDLE.
  - Avalon write in IDLE: performed in the same cycle, honouring byteenable, and only if debugaccess=1.
    - waitrequest=0 in that cycle; latency 1.
    - With debugaccess=0 the write is dropped but still acknowledged.
  - Avalon read: IDLE → AV_RD → AV_RD_CAP. In AV_RD_CAP, readdata is registered and waitrequest=0 for exactly one cycle; latency 3.
- waitrequest = (read|write) & ~ack. A master held off by JTAG priority keeps its request asserted and is served at the next IDLE.
- If read and write are both asserted, write wins.
- JTAG read latency from the strobe to MonDReg valid is at most 4 cycles when the FSM is idle. The debug-slave TCK path is orders of magnitude slower than this.
- Reset asserted mid-access aborts the access. A partially completed RAM write is not guaranteed.

Optional Feature:
- Macro: OCIMEM_AUTOINC_EN.
- Defined: after every completed JTAG write (JWR), MonAReg <= MonAReg+1, wrapping. This allows burst downloads using only take_action_ocimem_b strobes.
- Undefined: MonAReg changes only on take_action_ocimem_a and take_no_action_ocimem_a.

Decomposition:
- Package cpu_debug_ocimem_pkg holds:
  - the FSM state enum;
  - jdo field position constants (JDO_ADDR_LSB=17, JDO_RD_BIT=35, JDO_WDATA_MSB=34, JDO_WDATA_LSB=3).
- One sub-module: cpu_debug_ocimem_ram, a single-port RAM with byte enables and 1-cycle registered read, written for inference as block RAM.

Test Plan:
- Reset sequencing: assert reset mid-AV_RD, then release → waitrequest=1 during reset; MonDReg=0, MonAReg=0; FSM idle after release.
- JTAG write/read round trip:
  - take_action_ocimem_a with addr=0x10, rd=0;
  - then take_action_ocimem_b with data=0xDEADBEEF;
  - then take_action_ocimem_a with addr=0x10, rd=1;
  - expect MonDReg=0xDEADBEEF within 4 cycles.
- Sequential read with wrap:
  - set addr=0xFF;
  - three take_no_action_ocimem_a pulses;
  - expect MonAReg=0x00, 0x01, 0x02 and MonDReg equal to the RAM words at those addresses.
- Avalon write permission: write 0x12345678 to addr 5, byteenable=0xF, debugaccess=0 → read back returns the previous value. Repeat with debugaccess=1 → read returns 0x12345678 with latency 3.
- Byte lanes: write 0xAABBCCDD to addr 6, byteenable=0x5, over 0 → readback 0x00BB00DD.
- Contention: Avalon read asserted in the same cycle as a take_action_ocimem_b pulse → JWR completes first; the Avalon read completes afterwards with waitrequest held high until then. With OCIMEM_AUTOINC_EN defined, MonAReg has incremented by 1.

Source files
------------

// File: rtl/cpu_debug_ocimem_pkg.sv
// Shared types and jdo field positions for the on-chip debug memory controller.
package cpu_debug_ocimem_pkg;

  typedef enum logic [2:0] {
    IDLE,
    JWR,
    JRD,
    JRD_CAP,
    AV_RD,
    AV_RD_CAP
  } ocimem_state_t;

  localparam int JDO_ADDR_LSB  = 17;
  localparam int JDO_RD_BIT    = 35;
  localparam int JDO_WDATA_MSB = 34;
  localparam int JDO_WDATA_LSB = 3;

endpackage

// File: rtl/cpu_debug_ocimem_ram.sv
// Single-port monitor RAM: per-byte write enables, one-cycle registered read (read-first).
module cpu_debug_ocimem_ram #(
  parameter int ADDR_W = 8,
  parameter int DATA_W = 32
) (
  input  logic                  clk,
  input  logic [ADDR_W-1:0]     addr,
  input  logic                  we,
  input  logic [DATA_W/8-1:0]   be,
  input  logic [DATA_W-1:0]     wdata,
  output logic [DATA_W-1:0]     rdata
);

  logic [DATA_W-1:0] mem [0:(1<<ADDR_W)-1];

  always_ff @(posedge clk) begin
    if (we) begin
      for (int i = 0; i < DATA_W/8; i++) begin
        if (be[i]) mem[addr][i*8 +: 8] <= wdata[i*8 +: 8];
      end
    end
    rdata <= mem[addr];
  end

endmodule

// File: rtl/cpu_debug_ocimem_ctrl.sv
// Debug memory controller: arbitrates the JTAG (jdo/strobe) path and the Avalon debug slave
// onto the monitor RAM. Define OCIMEM_AUTOINC_EN to advance MonAReg after every JTAG write.
module cpu_debug_ocimem_ctrl
  import cpu_debug_ocimem_pkg::*;
#(
  parameter int ADDR_W = 8,
  parameter int DATA_W = 32
) (
  input  logic              clk,
  input  logic              reset,
  input  logic [37:0]       jdo,
  input  logic              take_action_ocimem_a,
  input  logic              take_no_action_ocimem_a,
  input  logic              take_action_ocimem_b,
  input  logic [ADDR_W-1:0] address,
  input  logic              read,
  input  logic              write,
  input  logic [DATA_W-1:0] writedata,
  input  logic [3:0]        byteenable,
  input  logic              debugaccess,
  output logic [DATA_W-1:0] readdata,
  output logic              waitrequest,
  output logic [DATA_W-1:0] MonDReg,
  output logic [ADDR_W-1:0] MonAReg
);

  ocimem_state_t state, state_next;
  logic              jrd_pend, jwr_pend;
  logic              jwr_req, jrd_req, jrd_strobe;
  logic              ack, jwr_done, jrd_done, av_rd_load;
  logic [ADDR_W-1:0] ram_addr;
  logic              ram_we;
  logic [3:0]        ram_be;
  logic [DATA_W-1:0] ram_wdata, ram_rdata;
  logic              unused_jdo;

  assign unused_jdo = ^{jdo[37:36], jdo[2:0]};

  // Strobes arriving this cycle count as pending so JTAG wins over a simultaneous Avalon request.
  assign jrd_strobe = take_no_action_ocimem_a | (take_action_ocimem_a & jdo[JDO_RD_BIT]);
  assign jwr_req    = jwr_pend | take_action_ocimem_b;
  assign jrd_req    = jrd_pend | jrd_strobe;

  always_comb begin
    state_next = state;
    ack        = 1'b0;
    jwr_done   = 1'b0;
    jrd_done   = 1'b0;
    av_rd_load = 1'b0;
    ram_addr   = address;
    ram_we     = 1'b0;
    ram_be     = byteenable;
    ram_wdata  = writedata;
    case (state)
      IDLE: begin
        if (jwr_req)      state_next = JWR;
        else if (jrd_req) state_next = JRD;
        else if (write) begin
          ack    = 1'b1;
          ram_we = debugaccess;
        end
        else if (read)    state_next = AV_RD;
      end
      JWR: begin
        ram_addr   = MonAReg;
        ram_we     = 1'b1;
        ram_be     = 4'hF;
        ram_wdata  = MonDReg;
        jwr_done   = 1'b1;
        state_next = IDLE;
      end
      JRD: begin
        ram_addr   = MonAReg;
        state_next = JRD_CAP;
      end
      JRD_CAP: begin
        jrd_done   = 1'b1;
        state_next = IDLE;
      end
      // RAM address was already presented in IDLE, so data is ready to register here.
      AV_RD: begin
        av_rd_load = 1'b1;
        state_next = AV_RD_CAP;
      end
      AV_RD_CAP: begin
        ack        = 1'b1;
        state_next = IDLE;
      end
      default: state_next = IDLE;
    endcase
  end

  assign waitrequest = reset | ((read | write) & ~ack);

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state    <= IDLE;
      jrd_pend <= 1'b0;
      jwr_pend <= 1'b0;
      MonAReg  <= '0;
      MonDReg  <= '0;
      readdata <= '0;
    end else begin
      state <= state_next;

      if (take_action_ocimem_a)         MonAReg <= jdo[JDO_ADDR_LSB +: ADDR_W];
      else if (take_no_action_ocimem_a) MonAReg <= MonAReg + 1'b1;
`ifdef OCIMEM_AUTOINC_EN
      else if (jwr_done)                MonAReg <= MonAReg + 1'b1;
`endif

      if (take_action_ocimem_b) MonDReg <= jdo[JDO_WDATA_MSB:JDO_WDATA_LSB];
      else if (jrd_done)        MonDReg <= ram_rdata;

      if (take_action_ocimem_b) jwr_pend <= 1'b1;
      else if (jwr_done)        jwr_pend <= 1'b0;

      if (jrd_strobe)    jrd_pend <= 1'b1;
      else if (jrd_done) jrd_pend <= 1'b0;

      if (av_rd_load) readdata <= ram_rdata;
    end
  end

  cpu_debug_ocimem_ram #(
    .ADDR_W (ADDR_W),
    .DATA_W (DATA_W)
  ) u_ram (
    .clk   (clk),
    .addr  (ram_addr),
    .we    (ram_we),
    .be    (ram_be),
    .wdata (ram_wdata),
    .rdata (ram_rdata)
  );

endmodule

// File: tb/tb_cpu_debug_ocimem_ctrl.sv
// Self-checking bench for cpu_debug_ocimem_ctrl against a word-array memory model.
module tb_cpu_debug_ocimem_ctrl;

  logic        clk = 1'b0;
  logic        reset;
  logic [37:0] jdo;
  logic        take_action_ocimem_a, take_no_action_ocimem_a, take_action_ocimem_b;
  logic [7:0]  address;
  logic        read, write;
  logic [31:0] writedata;
  logic [3:0]  byteenable;
  logic        debugaccess;
  logic [31:0] readdata;
  logic        waitrequest;
  logic [31:0] MonDReg;
  logic [7:0]  MonAReg;

  int checks = 0;
  int fails  = 0;

  logic [31:0] model_mem [256];
  logic [7:0]  m_areg;
  logic [31:0] m_dreg;

  always #5 clk = ~clk;

  cpu_debug_ocimem_ctrl dut (
    .clk                     (clk),
    .reset                   (reset),
    .jdo                     (jdo),
    .take_action_ocimem_a    (take_action_ocimem_a),
    .take_no_action_ocimem_a (take_no_action_ocimem_a),
    .take_action_ocimem_b    (take_action_ocimem_b),
    .address                 (address),
    .read                    (read),
    .write                   (write),
    .writedata               (writedata),
    .byteenable              (byteenable),
    .debugaccess             (debugaccess),
    .readdata                (readdata),
    .waitrequest             (waitrequest),
    .MonDReg                 (MonDReg),
    .MonAReg                 (MonAReg)
  );

  task automatic idle(input int n);
    repeat (n) begin @(posedge clk); #1; end
  endtask

  task automatic pulse_a(input logic [7:0] a, input logic rd);
    jdo = '0;
    jdo[24:17] = a;
    jdo[35] = rd;
    take_action_ocimem_a = 1'b1;
    @(posedge clk); #1;
    take_action_ocimem_a = 1'b0;
    m_areg = a;
    if (rd) m_dreg = model_mem[a];
  endtask

  task automatic pulse_na();
    take_no_action_ocimem_a = 1'b1;
    @(posedge clk); #1;
    take_no_action_ocimem_a = 1'b0;
    m_areg = m_areg + 8'd1;
    m_dreg = model_mem[m_areg];
  endtask

  task automatic pulse_b(input logic [31:0] d);
    jdo = '0;
    jdo[34:3] = d;
    take_action_ocimem_b = 1'b1;
    @(posedge clk); #1;
    take_action_ocimem_b = 1'b0;
    model_mem[m_areg] = d;
    m_dreg = d;
`ifdef OCIMEM_AUTOINC_EN
    m_areg = m_areg + 8'd1;
`endif
  endtask

  task automatic av_write(input logic [7:0] a, input logic [31:0] d, input logic [3:0] be,
                          input logic dbg, output int lat);
    logic done;
    address = a; writedata = d; byteenable = be; debugaccess = dbg; write = 1'b1;
    lat = 0; done = 1'b0;
    while (!done && lat < 50) begin
      @(negedge clk);
      lat++;
      done = !waitrequest;
      @(posedge clk); #1;
    end
    write = 1'b0;
    if (!done) lat = 99;
    else if (dbg) begin
      for (int i = 0; i < 4; i++)
        if (be[i]) model_mem[a][i*8 +: 8] = d[i*8 +: 8];
    end
  endtask

  task automatic av_read(input logic [7:0] a, input logic with_b, input logic [31:0] bdata,
                         output logic [31:0] data, output int lat);
    logic done;
    address = a; read = 1'b1;
    if (with_b) begin
      jdo = '0;
      jdo[34:3] = bdata;
      take_action_ocimem_b = 1'b1;
      model_mem[m_areg] = bdata;
      m_dreg = bdata;
`ifdef OCIMEM_AUTOINC_EN
      m_areg = m_areg + 8'd1;
`endif
    end
    lat = 0; done = 1'b0; data = 'x;
    while (!done && lat < 50) begin
      @(negedge clk);
      lat++;
      if (!waitrequest) begin done = 1'b1; data = readdata; end
      @(posedge clk); #1;
      take_action_ocimem_b = 1'b0;
    end
    read = 1'b0;
    if (!done) lat = 99;
  endtask

  task automatic test_reset();
    int lat;
    reset = 1'b1; read = 1'b1;
    repeat (2) @(posedge clk);
    #1;
    checks++; if (waitrequest !== 1'b1) begin fails++; $display("FAIL reset_waitrequest got %b exp 1", waitrequest); end
    checks++; if (MonDReg !== 32'h0) begin fails++; $display("FAIL reset_mondreg got %h exp 0", MonDReg); end
    checks++; if (MonAReg !== 8'h0) begin fails++; $display("FAIL reset_monareg got %h exp 0", MonAReg); end
    checks++; if (readdata !== 32'h0) begin fails++; $display("FAIL reset_readdata got %h exp 0", readdata); end
    read = 1'b0;
    reset = 1'b0;
    m_areg = '0; m_dreg = '0;
    idle(1);
    av_write(8'h40, $urandom, 4'hF, 1'b1, lat);
    checks++; if (lat !== 1) begin fails++; $display("FAIL reset_idle_write_latency got %0d exp 1", lat); end
  endtask

  task automatic test_round_trip();
    logic [7:0]  addrs [6];
    logic [31:0] d;
    pulse_a(8'h10, 1'b0);
    idle(1);
    checks++; if (MonAReg !== 8'h10) begin fails++; $display("FAIL rt_load_addr got %h exp 10", MonAReg); end
    pulse_b(32'hDEADBEEF);
    idle(3);
    pulse_a(8'h10, 1'b1);
    idle(3);
    @(negedge clk);
    checks++; if (MonDReg !== 32'hDEADBEEF) begin fails++; $display("FAIL rt_deadbeef got %h exp deadbeef", MonDReg); end
    @(posedge clk); #1;
    for (int i = 0; i < 6; i++) begin
      addrs[i] = 8'h80 + 8'(i * 7);
      d = $urandom;
      pulse_a(addrs[i], 1'b0);
      pulse_b(d);
      idle(3);
    end
    for (int i = 5; i >= 0; i--) begin
      pulse_a(addrs[i], 1'b1);
      idle(3);
      @(negedge clk);
      checks++; if (MonDReg !== m_dreg) begin fails++; $display("FAIL rt_random_read got %h exp %h", MonDReg, m_dreg); end
      checks++; if (MonAReg !== m_areg) begin fails++; $display("FAIL rt_random_addr got %h exp %h", MonAReg, m_areg); end
      @(posedge clk); #1;
    end
  endtask

  task automatic test_seq_wrap();
    int lat;
    logic [7:0] a;
    for (int i = 0; i < 4; i++) begin
      a = 8'hFF + 8'(i);
      av_write(a, $urandom, 4'hF, 1'b1, lat);
    end
    pulse_a(8'hFF, 1'b1);
    idle(3);
    @(negedge clk);
    checks++; if (MonDReg !== m_dreg) begin fails++; $display("FAIL wrap_start_data got %h exp %h", MonDReg, m_dreg); end
    @(posedge clk); #1;
    for (int i = 0; i < 3; i++) begin
      pulse_na();
      idle(3);
      @(negedge clk);
      checks++; if (MonAReg !== 8'(i)) begin fails++; $display("FAIL wrap_addr got %h exp %h", MonAReg, 8'(i)); end
      checks++; if (MonDReg !== m_dreg) begin fails++; $display("FAIL wrap_data got %h exp %h", MonDReg, m_dreg); end
      @(posedge clk); #1;
    end
  endtask

  task automatic test_av_permission();
    int lat;
    logic [31:0] prev, d;
    prev = $urandom;
    av_write(8'h05, prev, 4'hF, 1'b1, lat);
    av_write(8'h05, 32'h12345678, 4'hF, 1'b0, lat);
    checks++; if (lat !== 1) begin fails++; $display("FAIL perm_drop_ack_latency got %0d exp 1", lat); end
    av_read(8'h05, 1'b0, 32'h0, d, lat);
    checks++; if (d !== prev) begin fails++; $display("FAIL perm_dropped_write got %h exp %h", d, prev); end
    checks++; if (lat !== 3) begin fails++; $display("FAIL perm_read_latency got %0d exp 3", lat); end
    av_write(8'h05, 32'h12345678, 4'hF, 1'b1, lat);
    checks++; if (lat !== 1) begin fails++; $display("FAIL perm_write_latency got %0d exp 1", lat); end
    av_read(8'h05, 1'b0, 32'h0, d, lat);
    checks++; if (d !== 32'h12345678) begin fails++; $display("FAIL perm_write_data got %h exp 12345678", d); end
    checks++; if (lat !== 3) begin fails++; $display("FAIL perm_read2_latency got %0d exp 3", lat); end
  endtask

  task automatic test_byte_lanes();
    int lat;
    logic [31:0] d;
    logic [7:0] a;
    av_write(8'h06, 32'h0, 4'hF, 1'b1, lat);
    av_write(8'h06, 32'hAABBCCDD, 4'h5, 1'b1, lat);
    av_read(8'h06, 1'b0, 32'h0, d, lat);
    checks++; if (d !== 32'h00BB00DD) begin fails++; $display("FAIL lanes_fixed got %h exp 00bb00dd", d); end
    for (int i = 0; i < 8; i++) av_write(8'h40 + 8'(i), $urandom, 4'hF, 1'b1, lat);
    for (int i = 0; i < 16; i++) begin
      a = 8'h40 + 8'($urandom_range(0, 7));
      if ($urandom_range(0, 1) == 1)
        av_write(a, $urandom, 4'($urandom_range(0, 15)), 1'($urandom_range(0, 1)), lat);
      else begin
        av_read(a, 1'b0, 32'h0, d, lat);
        checks++; if (d !== model_mem[a]) begin fails++; $display("FAIL lanes_random addr %h got %h exp %h", a, d, model_mem[a]); end
      end
    end
  endtask

  task automatic test_contention();
    int lat;
    logic [31:0] d, bd;
    pulse_a(8'h20, 1'b0);
    idle(1);
    bd = $urandom;
    av_read(8'h20, 1'b1, bd, d, lat);
    checks++; if (d !== bd) begin fails++; $display("FAIL cont_read_after_jwr got %h exp %h", d, bd); end
    checks++; if (!(lat > 3 && lat < 50)) begin fails++; $display("FAIL cont_held_off latency got %0d exp >3", lat); end
    checks++; if (MonAReg !== m_areg) begin fails++; $display("FAIL cont_monareg got %h exp %h", MonAReg, m_areg); end
    checks++; if (MonDReg !== bd) begin fails++; $display("FAIL cont_mondreg got %h exp %h", MonDReg, bd); end
  endtask

  task automatic test_reset_mid_access();
    int lat;
    address = 8'h41; read = 1'b1;
    @(posedge clk); #1;
    @(negedge clk);
    reset = 1'b1;
    #1;
    checks++; if (waitrequest !== 1'b1) begin fails++; $display("FAIL mid_reset_waitrequest got %b exp 1", waitrequest); end
    checks++; if (MonDReg !== 32'h0) begin fails++; $display("FAIL mid_reset_mondreg got %h exp 0", MonDReg); end
    checks++; if (MonAReg !== 8'h0) begin fails++; $display("FAIL mid_reset_monareg got %h exp 0", MonAReg); end
    checks++; if (readdata !== 32'h0) begin fails++; $display("FAIL mid_reset_readdata got %h exp 0", readdata); end
    @(posedge clk); #1;
    read = 1'b0;
    reset = 1'b0;
    m_areg = '0; m_dreg = '0;
    idle(1);
    av_write(8'h42, $urandom, 4'hF, 1'b1, lat);
    checks++; if (lat !== 1) begin fails++; $display("FAIL mid_reset_idle_latency got %0d exp 1", lat); end
    pulse_a(8'h10, 1'b1);
    idle(3);
    @(negedge clk);
    checks++; if (MonDReg !== m_dreg) begin fails++; $display("FAIL mid_reset_ram_kept got %h exp %h", MonDReg, m_dreg); end
    @(posedge clk); #1;
  endtask

  initial begin
    reset = 1'b1;
    jdo = '0;
    take_action_ocimem_a = 1'b0;
    take_no_action_ocimem_a = 1'b0;
    take_action_ocimem_b = 1'b0;
    address = '0; read = 1'b0; write = 1'b0;
    writedata = '0; byteenable = 4'hF; debugaccess = 1'b0;
    test_reset();
    test_round_trip();
    test_seq_wrap();
    test_av_permission();
    test_byte_lanes();
    test_contention();
    test_reset_mid_access();
    $display("End of test - %0d assertions evaluated, %0d failures", checks, fails);
    $finish;
  end

endmodule
